pipelined_csa_multiplier: RTL
=============================

# pipelined_csa_multiplier

- Parametrised, pipelined carry-save-tree integer multiplier: one WIDTH x WIDTH product per clock, full 2*WIDTH-bit result.
- Valid/ready handshake at both ends, per-transaction signed/unsigned mode and a sideband tag.
- Successor to the team's fixed 24-bit combinational array multiplier.
- Feeds the FP mantissa datapath (WIDTH=24) and integer MUL units (WIDTH=32).

## Interface
Parameters:
- WIDTH, 24: operand width; legal range 4..64.
- STAGES, 3: pipeline depth in cycles; legal range 1..8; must not exceed reduction levels + 1.
- TAG_W, 4: sideband tag width; legal minimum is 1.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- in_a  in  WIDTH  multiplicand
- in_b  in  WIDTH  multiplier
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_tag  in  TAG_W  carried unchanged with the product
- out_valid  out  1  product present
- out_ready  in  1  consumer accepts product
- out_product  out  2*WIDTH  full product
- out_tag  out  TAG_W  tag of that product

## Operation
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Partial products: WIDTH rows of in_a AND in_b[i], shifted left by i.
- Signed mode: Baugh-Wooley correction, i.e. inverted MSB terms plus constants at bits WIDTH and 2*WIDTH-1.
- Reduction: 3:2 carry-save layers down to two rows. A final carry-propagate adder produces the product modulo 2^(2*WIDTH).
- Result is always exact; no overflow is possible.
  - Unsigned max: (2^W-1)^2.
  - Signed max: (-2^(W-1))^2 = 2^(2W-2).
- Pipeline registers: STAGES register banks, each holding a valid bit, tag and partial-sum state.
  - Bank 0 sits after the first reduction layer.
  - The last bank holds the final sum.
  - Intermediate banks are spread evenly across the layer count (position is implementation-free).
- Stall is global: advance = !out_valid || out_ready; in_ready = advance.
  - When advance=0, every bank holds its contents.
  - Bubbles are not squeezed out.
- Ordering is strictly in order; tags are never reordered.
- Reset (asynchronous, any cycle, including mid-flight):
  - All valid bits clear, out_valid=0, out_product=0, out_tag=0.
  - in_ready=1 immediately after deassertion.
  - In-flight transactions are discarded without output.
- in_signed is sampled with the operands and travels with them through the pipeline.

## Timing
- Latency: exactly STAGES cycles from input transfer to out_valid, with out_ready held high.
- Throughput: 1 product/cycle with out_ready held high.
- in_ready is combinational from out_ready and out_valid only. There is no combinational path from in_valid to in_ready.
- out_valid, out_product and out_tag are registered outputs. They stay stable while out_valid && !out_ready.
- Simultaneous output transfer and input transfer in the same cycle is legal and required for full throughput.
- With STAGES=1, the single bank holds the final sum and the whole tree is combinational in front of it.

## Configuration
- PIPE_MULT_SIGNED_EN defined: in_signed is honoured and the Baugh-Wooley correction logic is built.
- PIPE_MULT_SIGNED_EN undefined:
  - in_signed is ignored and all operations are unsigned.
  - The correction logic and the in_signed pipeline bit are not synthesised.
  - The port is retained so the interface is stable.

## Structure
- Package mult_pkg holds:
  - Function csa_levels(rows), returning the number of 3:2 layers needed to reduce rows to 2.
  - Function stage_of_level(level, levels, stages), mapping a tree layer to a register bank.
  - Localparam for maximum WIDTH.
- One sub-module, csa_layer:
  - Parametrised on row width.
  - Reduces three rows to sum and carry (carry shifted left by 1).
  - Instantiated in generate loops per layer.
- Final carry-propagate add is inline (behavioural +).

## Test plan
- Unsigned max, WIDTH=24, STAGES=3: a=0xFFFFFF, b=0xFFFFFF -> out_product=0xFFFFFE000001, out_valid exactly 3 cycles after input transfer.
- Mode contrast:
  - a=0xFFFFFF, b=0x000001, signed=1 -> 0xFFFFFFFFFFFF.
  - Same operands with signed=0 -> 0x000000FFFFFF.
  - Without PIPE_MULT_SIGNED_EN, both give 0x000000FFFFFF.
- Signed extreme: a=0x800000, b=0x800000, signed=1 -> 0x400000000000; a=0x800000, b=0x000001, signed=1 -> 0xFFFFFF800000.
- Back-to-back with backpressure:
  - Stimulus: 10 consecutive transactions with tags 0..9; out_ready low for cycles 4-7.
  - Required: in_ready low during the stall, no loss or duplication, tags emerge 0..9 in order, output stable while stalled.
- Reset mid-flight: assert rst with 3 transactions in the pipeline -> out_valid=0 and out_product=0 same cycle; no stale output after deassertion.
- Random sweep: 10k random operands, modes and out_ready patterns, over WIDTH in {8,24,32} x STAGES in {1,2,4}. Results must match the behavioural model.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared sizing helpers for the carry-save multiplier: tree depth and
// placement of pipeline register banks along the reduction layers.
package mult_pkg;

    localparam int MAX_WIDTH = 64;

    function automatic int rows_next(input int rows);
        return 2 * (rows / 3) + rows % 3;
    endfunction

    function automatic int csa_levels(input int rows);
        int r;
        int n;
        r = rows;
        n = 0;
        while (r > 2) begin
            r = rows_next(r);
            n++;
        end
        return n;
    endfunction

    function automatic int rows_at(input int rows, input int level);
        int r;
        r = rows;
        for (int i = 0; i < level; i++) r = rows_next(r);
        return r;
    endfunction

    // Bank k (k < stages-1) closes layer (k*levels)/(stages-1); the last bank
    // always holds the final sum. Returns -1 when the layer feeds on unregistered.
    function automatic int stage_of_level(input int level, input int levels, input int stages);
        int b;
        b = -1;
        for (int k = 0; k < stages - 1; k++)
            if ((k * levels) / (stages - 1) == level) b = k;
        return b;
    endfunction

endpackage

// File: rtl/csa_layer.sv
// One 3:2 carry-save compressor row: three operands in, sum and
// left-shifted carry out.
module csa_layer #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    assign sum_o   = a_i ^ b_i ^ c_i;
    assign carry_o = {(a_i[W-2:0] & b_i[W-2:0]) |
                      (a_i[W-2:0] & c_i[W-2:0]) |
                      (b_i[W-2:0] & c_i[W-2:0]), 1'b0};

endmodule

// File: rtl/pipelined_csa_multiplier.sv
// Pipelined carry-save-tree multiplier with valid/ready handshake and tag.
// Define PIPE_MULT_SIGNED_EN to honour in_signed (Baugh-Wooley correction).
module pipelined_csa_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int PW     = 2 * WIDTH;
    localparam int LEVELS = csa_levels(WIDTH);

    logic             advance;
    logic [PW-1:0]    pp     [WIDTH];
    logic [PW-1:0]    lin    [LEVELS+1][WIDTH];
    logic [PW-1:0]    lout   [LEVELS][WIDTH];
    logic             vin    [LEVELS+1];
    logic [TAG_W-1:0] tin    [LEVELS+1];
    logic [PW-1:0]    sum_d;
    logic             valid_q;
    logic [PW-1:0]    prod_q;
    logic [TAG_W-1:0] tag_q;

    assign advance  = !valid_q || out_ready;
    assign in_ready = advance;

`ifndef PIPE_MULT_SIGNED_EN
    logic unused_signed;
    assign unused_signed = in_signed;
`endif

    // Signed rows: terms pairing exactly one operand MSB are inverted, and the
    // +2^W / +2^(2W-1) constants sit in the free upper bits of row 0.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp[i] = '0;
            for (int j = 0; j < WIDTH; j++) begin
                pp[i][i+j] = in_a[j] & in_b[i];
`ifdef PIPE_MULT_SIGNED_EN
                if (in_signed && ((i == WIDTH - 1) != (j == WIDTH - 1)))
                    pp[i][i+j] = ~(in_a[j] & in_b[i]);
`endif
            end
        end
`ifdef PIPE_MULT_SIGNED_EN
        if (in_signed) begin
            pp[0][WIDTH] = 1'b1;
            pp[0][PW-1]  = 1'b1;
        end
`endif
    end

    for (genvar r = 0; r < WIDTH; r++) begin : g_rows0
        assign lin[0][r] = pp[r];
    end
    assign vin[0] = in_valid;
    assign tin[0] = in_tag;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N = rows_at(WIDTH, l);
        localparam int G = N / 3;

        for (genvar g = 0; g < G; g++) begin : g_csa
            csa_layer #(.W(PW)) u_csa (
                .a_i     (lin[l][3*g]),
                .b_i     (lin[l][3*g+1]),
                .c_i     (lin[l][3*g+2]),
                .sum_o   (lout[l][2*g]),
                .carry_o (lout[l][2*g+1])
            );
        end

        for (genvar r = 2 * G; r < WIDTH; r++) begin : g_pass
            if (r < 2 * G + N % 3) begin : g_left
                assign lout[l][r] = lin[l][3*G + r - 2*G];
            end else begin : g_zero
                assign lout[l][r] = '0;
            end
        end

        if (stage_of_level(l, LEVELS, STAGES) >= 0) begin : g_bank
            logic [PW-1:0]    rows_q [WIDTH];
            logic             vld_q;
            logic [TAG_W-1:0] tagb_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)          vld_q <= 1'b0;
                else if (advance) vld_q <= vin[l];
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    for (int r = 0; r < WIDTH; r++) rows_q[r] <= lout[l][r];
                    tagb_q <= tin[l];
                end
            end

            for (genvar r = 0; r < WIDTH; r++) begin : g_out
                assign lin[l+1][r] = rows_q[r];
            end
            assign vin[l+1] = vld_q;
            assign tin[l+1] = tagb_q;
        end else begin : g_comb
            for (genvar r = 0; r < WIDTH; r++) begin : g_out
                assign lin[l+1][r] = lout[l][r];
            end
            assign vin[l+1] = vin[l];
            assign tin[l+1] = tin[l];
        end
    end

    assign sum_d = lin[LEVELS][0] + lin[LEVELS][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            prod_q  <= '0;
            tag_q   <= '0;
        end else if (advance) begin
            valid_q <= vin[LEVELS];
            prod_q  <= sum_d;
            tag_q   <= tin[LEVELS];
        end
    end

    assign out_valid   = valid_q;
    assign out_product = prod_q;
    assign out_tag     = tag_q;

endmodule
